// File: rtl/rand_stim_pkg.sv
// Shared constants, enums and seed/LFSR helpers for the multi-channel
// pseudo-random stimulus source.
package rand_stim_pkg;

    localparam logic [31:0] RSG_TAPS32   = 32'h8020_0003;
    localparam logic [31:0] GOLDEN_RATIO = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        MODE_FREE  = 2'd0,
        MODE_BURST = 2'd1,
        MODE_STEP  = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } ch_state_e;

    // An all-zero Galois LFSR state never leaves zero, so it is replaced by 1.
    function automatic logic [31:0] seed_for(input logic [31:0] seed, input logic [31:0] ch);
        logic [31:0] mix;
        mix = seed ^ (ch * GOLDEN_RATIO);
        return (mix == 32'h0) ? 32'h1 : mix;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? RSG_TAPS32 : 32'h0);
    endfunction

endpackage

// File: rtl/rand_stim_lane.sv
// One stimulus channel: Galois LFSR, outstanding-word counter and the
// IDLE/ACTIVE state machine that owns the channel's valid.
module rand_stim_lane
    import rand_stim_pkg::*;
#(
    parameter int          CH        = 0,
    parameter int          DATA_W    = 32,
    parameter int          LFSR_W    = 32,
    parameter int          BURST_W   = 8,
    parameter logic [31:0] SEED_BASE = 32'hACE1_0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  mode_e              mode,
    input  logic               start_ok,
    input  logic [BURST_W-1:0] load_len,
    input  logic               reseed,
    input  logic [31:0]        seed,
    input  logic               ready,
    output ch_state_e          state_dbg,
    output logic [DATA_W-1:0]  data,
    output logic               rem_nz
);

    logic [LFSR_W-1:0]  lfsr;
    logic [BURST_W-1:0] rem;
    logic [BURST_W-1:0] rem_dec;
    logic               hs;

    // Handshake: a word transfers on any edge where valid (state == ACTIVE)
    // and ready are both high; the LFSR then advances so the next word is
    // presented the following cycle. Data/valid never depend on ready.
    assign hs      = (state_dbg == CH_ACTIVE) && ready;
    assign rem_dec = (rem != '0) ? rem - 1'b1 : '0;
    assign rem_nz  = (rem != '0);
    assign data    = lfsr[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= seed_for(SEED_BASE, 32'(CH));
            rem       <= '0;
            state_dbg <= CH_IDLE;
        end else if (reseed) begin
            lfsr      <= seed_for(seed, 32'(CH));
            rem       <= '0;
            state_dbg <= CH_IDLE;
        end else begin
            if (hs)
                lfsr <= lfsr_next(lfsr);
            case (mode)
                MODE_FREE: begin
                    rem <= '0;
                    if (state_dbg == CH_IDLE) begin
                        if (en)
                            state_dbg <= CH_ACTIVE;
                    end else if (hs && !en) begin
                        state_dbg <= CH_IDLE;
                    end
                end
                MODE_BURST, MODE_STEP: begin
                    if (start_ok) begin
                        rem <= load_len;
                        if (load_len != '0)
                            state_dbg <= CH_ACTIVE;
                        else if (hs)
                            state_dbg <= CH_IDLE;
                    end else if (state_dbg == CH_ACTIVE) begin
                        if (hs) begin
                            rem <= rem_dec;
                            if (rem_dec == '0)
                                state_dbg <= CH_IDLE;
                        end
                    end else if (rem != '0) begin
                        // Resume a burst that was parked by HOLD.
                        state_dbg <= CH_ACTIVE;
                    end
                end
                default: begin
                    if (hs) begin
                        rem       <= rem_dec;
                        state_dbg <= CH_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/rand_stim_source.sv
// Multi-channel pseudo-random stimulus source with per-channel valid/ready,
// runtime reseed and FREE/BURST/STEP/HOLD modes.
module rand_stim_source
    import rand_stim_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          DATA_W    = 32,
    parameter int          LFSR_W    = 32,
    parameter logic [31:0] SEED_BASE = 32'hACE1_0001,
    parameter int          BURST_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [BURST_W-1:0]       burst_len,
    input  logic                     start,
    input  logic                     reseed,
    input  logic [31:0]              seed,
    input  logic [NUM_CH-1:0]        ready,
    output logic [NUM_CH-1:0]        valid,
    output logic [NUM_CH*DATA_W-1:0] data,
    output logic                     busy,
    output logic [31:0]              word_count
);

    mode_e              mode_sel;
    logic               start_ok;
    logic [BURST_W-1:0] load_len;
    logic [NUM_CH-1:0]  rem_nz;
    ch_state_e          lane_state [NUM_CH];

    assign mode_sel = mode_e'(mode);
    // Reseed wins over start; a start during an outstanding burst is dropped.
    assign start_ok = start && en && !busy && !reseed &&
                      (mode_sel == MODE_BURST || mode_sel == MODE_STEP);
    assign load_len = (mode_sel == MODE_STEP) ? BURST_W'(1) : burst_len;
    assign busy     = |rem_nz;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        rand_stim_lane #(
            .CH        (c),
            .DATA_W    (DATA_W),
            .LFSR_W    (LFSR_W),
            .BURST_W   (BURST_W),
            .SEED_BASE (SEED_BASE)
        ) u_lane (
            .clk       (clk),
            .rst       (reset),
            .en        (en),
            .mode      (mode_sel),
            .start_ok  (start_ok),
            .load_len  (load_len),
            .reseed    (reseed),
            .seed      (seed),
            .ready     (ready[c]),
            .state_dbg (lane_state[c]),
            .data      (data[c*DATA_W +: DATA_W]),
            .rem_nz    (rem_nz[c])
        );
        assign valid[c] = (lane_state[c] == CH_ACTIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            word_count <= '0;
        else if (valid[0] && ready[0])
            word_count <= word_count + 32'd1;
    end

endmodule

// File: tb/tb_rand_stim_source.sv
// Directed bench for rand_stim_source: channel-0 words are scored against an
// expected queue filled from an LFSR model; control behaviour checked inline.
module tb_rand_stim_source;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     en = 1'b0;
    logic [1:0]               mode = 2'd0;
    logic [BURST_W-1:0]       burst_len = '0;
    logic                     start = 1'b0;
    logic                     reseed = 1'b0;
    logic [31:0]              seed = '0;
    logic [NUM_CH-1:0]        ready = '0;
    logic [NUM_CH-1:0]        valid;
    logic [NUM_CH*DATA_W-1:0] data;
    logic                     busy;
    logic [31:0]              word_count;

    int          tests = 0;
    int          fails = 0;
    int          exp_wc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m0;
    logic [31:0] m1;

    rand_stim_source #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .LFSR_W    (32),
        .SEED_BASE (32'hACE1_0001),
        .BURST_W   (BURST_W)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .en         (en),
        .mode       (mode),
        .burst_len  (burst_len),
        .start      (start),
        .reseed     (reseed),
        .seed       (seed),
        .ready      (ready),
        .valid      (valid),
        .data       (data),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] model_seed(input logic [31:0] s, input int c);
        logic [31:0] r;
        r = s ^ (32'(c) * 32'h9E37_79B9);
        return (r == 32'h0) ? 32'h1 : r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m0);
            m0 = model_next(m0);
            exp_wc++;
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            tick(1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Channel-0 scoreboard: a word is consumed on the edge following a
    // negedge where valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && valid[0] && ready[0]) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", data[31:0], 32'hxxxx_xxxx);
            end else begin
                chk("ch0_word", data[31:0], exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset values
        tick(2);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wc", word_count, 32'h0);
        chk("rst_ch0_state", data[31:0], model_seed(32'hACE1_0001, 0));
        chk("rst_ch1_state", data[63:32], model_seed(32'hACE1_0001, 1));
        rst = 1'b0;
        tick(1);

        // Reseed to 1, FREE run with three back-to-back handshakes
        seed = 32'h1;
        reseed = 1'b1;
        tick(1);
        reseed = 1'b0;
        chk("reseed_ch0", data[31:0], 32'h0000_0001);
        chk("reseed_ch1", data[63:32], 32'h9E37_79B8);
        chk("reseed_valid", 32'(valid), 32'h0);
        m0 = model_seed(32'h1, 0);
        m1 = model_seed(32'h1, 1);
        en = 1'b1;
        tick(1);
        chk("free_valid_rise", 32'(valid), 32'hF);
        chk("ch0_first", data[31:0], 32'h0000_0001);
        push_words(3);
        ready = 4'hF;
        tick(3);
        ready = 4'h0;
        for (int i = 0; i < 3; i++)
            m1 = model_next(m1);
        chk("ch0_third_next", data[31:0], model_next(32'hC030_0002));
        chk("ch1_after3", data[63:32], m1);
        chk("free_wc", word_count, 32'(exp_wc));

        // Back-pressure on ch0: word holds, then one advance per handshake
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid0", 32'(valid[0]), 32'h1);
            chk("stall_data0", data[31:0], m0);
            tick(1);
        end
        for (int k = 0; k < 2; k++) begin
            push_words(1);
            ready = 4'b0001;
            tick(1);
            ready = 4'h0;
            tick(2);
            chk("single_adv_data0", data[31:0], m0);
            chk("single_adv_wc", word_count, 32'(exp_wc));
        end

        // BURST of 3, with an ignored start while busy
        mode = 2'd1;
        push_words(1);
        ready = 4'hF;
        tick(1);
        ready = 4'h0;
        chk("burst_idle_valid", 32'(valid), 32'h0);
        chk("burst_idle_busy", 32'(busy), 32'h0);
        burst_len = 8'd3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("burst_busy0", 32'(busy), 32'h1);
        chk("burst_valid", 32'(valid), 32'hF);
        push_words(3);
        ready = 4'hF;
        tick(1);
        chk("burst_busy1", 32'(busy), 32'h1);
        burst_len = 8'd7;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("burst_busy2", 32'(busy), 32'h1);
        tick(1);
        chk("burst_done_busy", 32'(busy), 32'h0);
        chk("burst_done_valid", 32'(valid), 32'h0);
        tick(4);
        chk("burst_no_extra", 32'(valid), 32'h0);
        drain(4);
        chk("burst_wc", word_count, 32'(exp_wc));

        // burst_len = 0 produces nothing
        burst_len = 8'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("len0_valid", 32'(valid), 32'h0);
        chk("len0_busy", 32'(busy), 32'h0);
        tick(2);
        chk("len0_valid_later", 32'(valid), 32'h0);

        // STEP: three single words spaced 4 cycles
        mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            push_words(1);
            start = 1'b1;
            tick(1);
            start = 1'b0;
            chk("step_valid", 32'(valid[0]), 32'h1);
            chk("step_busy", 32'(busy), 32'h1);
            tick(3);
            chk("step_idle", 32'(valid), 32'h0);
            chk("step_not_busy", 32'(busy), 32'h0);
        end
        chk("step_wc", word_count, 32'(exp_wc));

        // Reseed while valid_0 stalled; zero-substitution on ch1
        ready = 4'h0;
        mode = 2'd0;
        en = 1'b1;
        tick(2);
        chk("free_again_valid", 32'(valid), 32'hF);
        seed = 32'h9E37_79B9;
        reseed = 1'b1;
        tick(1);
        reseed = 1'b0;
        chk("reseed_drop_valid", 32'(valid), 32'h0);
        chk("reseed_ch0_val", data[31:0], 32'h9E37_79B9);
        chk("reseed_ch1_zero", data[63:32], 32'h0000_0001);
        m0 = model_seed(seed, 0);
        tick(1);
        chk("reseed_valid_back", 32'(valid), 32'hF);

        // Handshake in the same cycle as reseed is still counted
        push_words(1);
        ready = 4'b0001;
        seed = 32'h1;
        reseed = 1'b1;
        tick(1);
        reseed = 1'b0;
        ready = 4'h0;
        chk("reseed_hs_valid", 32'(valid), 32'h0);
        chk("reseed_hs_wc", word_count, 32'(exp_wc));
        m0 = model_seed(32'h1, 0);
        chk("reseed_hs_ch0", data[31:0], m0);
        tick(1);

        // Mid-burst HOLD, then resume
        mode = 2'd1;
        push_words(1);
        ready = 4'hF;
        tick(1);
        ready = 4'h0;
        chk("hold_pre_valid", 32'(valid), 32'h0);
        burst_len = 8'd5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("hold_burst_valid", 32'(valid), 32'hF);
        mode = 2'd3;
        push_words(1);
        ready = 4'hF;
        tick(1);
        chk("hold_valid_drop", 32'(valid), 32'h0);
        chk("hold_busy", 32'(busy), 32'h1);
        tick(3);
        chk("hold_still_idle", 32'(valid), 32'h0);
        chk("hold_still_busy", 32'(busy), 32'h1);
        mode = 2'd1;
        push_words(4);
        tick(5);
        chk("resume_done_valid", 32'(valid), 32'h0);
        chk("resume_done_busy", 32'(busy), 32'h0);
        drain(4);
        chk("resume_wc", word_count, 32'(exp_wc));

        // Asynchronous reset mid-burst
        ready = 4'h0;
        burst_len = 8'd10;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("arst_pre_busy", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_wc", word_count, 32'h0);
        chk("arst_ch0", data[31:0], model_seed(32'hACE1_0001, 0));
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("post_rst_valid", 32'(valid), 32'h0);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
